// File: rtl/cls_seq_pkg.sv
// Shared types and constants for the PMOD CLS text refresh sequencer:
// FSM state encoding, refresh period arithmetic and wait-state successor lookup.
package cls_seq_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CLR_ISSUE = 4'd1,
    CLR_WBUSY = 4'd2,
    CLR_WDONE = 4'd3,
    L1_ISSUE  = 4'd4,
    L1_WBUSY  = 4'd5,
    L1_WDONE  = 4'd6,
    L2_ISSUE  = 4'd7,
    L2_WBUSY  = 4'd8,
    L2_WDONE  = 4'd9
  } t_cls_seq_state;

  localparam int unsigned c_fast_refresh_ticks = 1000;

  // 64-bit intermediate so large ce rates times long periods cannot overflow.
  function automatic int unsigned refresh_terminal(input int unsigned fclk_ce,
                                                   input int unsigned refresh_ms);
    logic [63:0] ticks;
    ticks = 64'(fclk_ce) * 64'(refresh_ms) / 64'd1000;
    return 32'(ticks - 64'd1);
  endfunction

  function automatic t_cls_seq_state wait_next(input t_cls_seq_state s);
    case (s)
      CLR_WBUSY: return CLR_WDONE;
      CLR_WDONE: return L1_ISSUE;
      L1_WBUSY:  return L1_WDONE;
      L1_WDONE:  return L2_ISSUE;
      L2_WBUSY:  return L2_WDONE;
      default:   return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cls_refresh_timer.sv
// ce-gated wrap counter: counts while enabled, clears on request, and pulses
// tc_o on the ce tick where it wraps from the terminal count back to zero.
module cls_refresh_timer #(
  parameter int unsigned TC = 999
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int W = (TC > 0) ? $clog2(TC + 1) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_tc_w;

  assign at_tc_w = (cnt_q == W'(TC));
  assign tc_o    = ce_i && en_i && !clr_i && at_tc_w;

  always_comb begin
    cnt_d = cnt_q;
    if (ce_i) begin
      if (clr_i) cnt_d = '0;
      else if (en_i) cnt_d = at_tc_w ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cls_text_refresh_sequencer.sv
// Command source for the PMOD CLS driver: snapshots two text lines and issues
// clear / line1 / line2 commands on request or on a periodic refresh.
module cls_text_refresh_sequencer
  import cls_seq_pkg::*;
#(
  parameter int parm_fast_simulation = 0,
  parameter int FCLK_ce              = 2500000,
  parameter int parm_refresh_ms      = 200,
  parameter int parm_ready_timeout   = 65535
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_ce_2_5mhz,
  input  logic         i_update_req,
  input  logic         i_clear_enable,
  input  logic [127:0] i_dat_line1,
  input  logic [127:0] i_dat_line2,
  input  logic         i_command_ready,
  output logic         o_cmd_wr_clear_display,
  output logic         o_cmd_wr_text_line1,
  output logic         o_cmd_wr_text_line2,
  output logic [127:0] o_dat_ascii_line1,
  output logic [127:0] o_dat_ascii_line2,
  output logic         o_busy,
  output logic         o_frame_done,
  output logic         o_timeout_err,
  output logic [3:0]   o_dbg_state
);

  localparam int unsigned c_refresh_tc = (parm_fast_simulation != 0) ?
      c_fast_refresh_ticks - 1 :
      refresh_terminal(32'(FCLK_ce), 32'(parm_refresh_ms));
  localparam int c_wd_w = $clog2(parm_ready_timeout + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(parm_ready_timeout - 1);

  t_cls_seq_state     state_q, next_wait_w;
  logic               pending_q, pending_d;
  logic [c_wd_w-1:0]  wd_q;
  logic               clr_q, l1_q, l2_q, busy_q, done_q, err_q;
  logic [127:0]       line1_q, line2_q;
  logic               in_wbusy_w, in_wdone_w, wait_met_w;
  logic               start_w, wd_expire_w, refresh_tc_w;

  // Handshake: a strobe is held for one ce period; the driver accepts it by
  // dropping i_command_ready and signals completion by raising it again.
  assign in_wbusy_w  = state_q inside {CLR_WBUSY, L1_WBUSY, L2_WBUSY};
  assign in_wdone_w  = state_q inside {CLR_WDONE, L1_WDONE, L2_WDONE};
  assign wait_met_w  = (in_wbusy_w && !i_command_ready) || (in_wdone_w && i_command_ready);
  assign start_w     = i_ce_2_5mhz && (state_q == IDLE) && pending_q && i_command_ready;
  assign wd_expire_w = i_ce_2_5mhz && (in_wbusy_w || in_wdone_w) && !wait_met_w &&
                       (wd_q == c_wd_last);
  assign next_wait_w = wait_next(state_q);

  // Set sources win over the start-of-sequence clear; update_req is not ce-gated.
  assign pending_d = (i_update_req || refresh_tc_w || wd_expire_w) ? 1'b1 :
                     (start_w ? 1'b0 : pending_q);

  cls_refresh_timer #(.TC(c_refresh_tc)) u_refresh_timer (
    .clk_i (i_clk_20mhz),
    .rst_i (i_rst_20mhz),
    .ce_i  (i_ce_2_5mhz),
    .en_i  (state_q == IDLE),
    .clr_i (start_w),
    .tc_o  (refresh_tc_w)
  );

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      wd_q      <= '0;
      clr_q     <= 1'b0;
      l1_q      <= 1'b0;
      l2_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      line1_q   <= '0;
      line2_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (i_ce_2_5mhz) begin
        clr_q  <= 1'b0;
        l1_q   <= 1'b0;
        l2_q   <= 1'b0;
        done_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (start_w) begin
              line1_q <= i_dat_line1;
              line2_q <= i_dat_line2;
              busy_q  <= 1'b1;
              if (i_clear_enable) begin
                state_q <= CLR_ISSUE;
                clr_q   <= 1'b1;
              end else begin
                state_q <= L1_ISSUE;
                l1_q    <= 1'b1;
              end
            end
          end
          CLR_ISSUE: begin wd_q <= '0; state_q <= CLR_WBUSY; end
          L1_ISSUE:  begin wd_q <= '0; state_q <= L1_WBUSY;  end
          L2_ISSUE:  begin wd_q <= '0; state_q <= L2_WBUSY;  end
          default: begin
            if (wait_met_w) begin
              state_q <= next_wait_w;
              if (next_wait_w == L1_ISSUE) l1_q <= 1'b1;
              if (next_wait_w == L2_ISSUE) l2_q <= 1'b1;
              if (state_q == L2_WDONE) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
              wd_q <= wd_q + 1'b1;
            end else if (wd_expire_w) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign o_cmd_wr_clear_display = clr_q;
  assign o_cmd_wr_text_line1    = l1_q;
  assign o_cmd_wr_text_line2    = l2_q;
  assign o_dat_ascii_line1      = line1_q;
  assign o_dat_ascii_line2      = line2_q;
  assign o_busy                 = busy_q;
  assign o_frame_done           = done_q;
  assign o_timeout_err          = err_q;
  assign o_dbg_state            = state_q;

endmodule

// File: tb/tb_cls_text_refresh_sequencer.sv
// Scoreboard bench for the CLS text refresh sequencer with a model display
// driver, randomized text lines and a monitor comparing every command strobe.
`timescale 1ns/1ps
module tb_cls_text_refresh_sequencer;
  import cls_seq_pkg::*;

  localparam int EW = 259;
  localparam logic [1:0] K_CLR = 2'd1, K_L1 = 2'd2, K_L2 = 2'd3;

  logic         clk = 1'b0, rst = 1'b0, ce = 1'b0;
  logic         update_req = 1'b0, clear_enable = 1'b1, command_ready = 1'b1;
  logic [127:0] line1 = '0, line2 = '0;
  logic         wr_clr, wr_l1, wr_l2, busy, frame_done, timeout_err;
  logic [127:0] dat1, dat2;
  logic [3:0]   dbg_state;

  int errors = 0, checks = 0;
  logic [EW-1:0] exp_q[$];
  int exp_frames = 0, done_count = 0, strobe_count = 0;
  int ce_count = 0, last_strobe_ce = 0, last_done_ce = 0;
  bit stuck = 1'b0;

  cls_text_refresh_sequencer #(
    .parm_fast_simulation(1),
    .FCLK_ce(2500000),
    .parm_refresh_ms(200),
    .parm_ready_timeout(100)
  ) dut (
    .i_clk_20mhz(clk),
    .i_rst_20mhz(rst),
    .i_ce_2_5mhz(ce),
    .i_update_req(update_req),
    .i_clear_enable(clear_enable),
    .i_dat_line1(line1),
    .i_dat_line2(line2),
    .i_command_ready(command_ready),
    .o_cmd_wr_clear_display(wr_clr),
    .o_cmd_wr_text_line1(wr_l1),
    .o_cmd_wr_text_line2(wr_l2),
    .o_dat_ascii_line1(dat1),
    .o_dat_ascii_line2(dat2),
    .o_busy(busy),
    .o_frame_done(frame_done),
    .o_timeout_err(timeout_err),
    .o_dbg_state(dbg_state)
  );

  // clock / reset / ce
  always #25 clk = ~clk;

  initial begin : ce_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ce = (ph == 7);
      ph = (ph + 1) % 8;
    end
  end

  initial begin : ce_counter
    forever begin
      @(posedge clk);
      if (ce) ce_count++;
    end
  end

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [127:0] rand_line();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'($urandom_range(32, 126));
    return v;
  endfunction

  task automatic wait_ce();
    do @(posedge clk); while (!ce);
    #1;
  endtask

  // driver tasks
  task automatic push_frame(input bit cen, input logic [127:0] l1, input logic [127:0] l2);
    if (cen) exp_q.push_back({K_CLR, 1'b1, l1, l2});
    exp_q.push_back({K_L1, 1'b1, l1, l2});
    exp_q.push_back({K_L2, 1'b1, l1, l2});
    exp_frames++;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
  endtask

  task automatic wait_frames(input string name);
    int n;
    n = 0;
    while (done_count < exp_frames && n < 20000) begin @(negedge clk); n++; end
    check(name, done_count, exp_frames);
  endtask

  task automatic wait_strobes(input int target, input string name);
    int n;
    n = 0;
    while (strobe_count < target && n < 12000) begin @(negedge clk); n++; end
    check(name, strobe_count, target);
  endtask

  task automatic run_frame(input bit cen, input logic [127:0] l1, input logic [127:0] l2,
                           input string name);
    int n;
    clear_enable = cen;
    line1 = l1;
    line2 = l2;
    push_frame(cen, l1, l2);
    pulse_req();
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    check("busy_rise", busy, 1);
    line1 = rand_line();
    line2 = rand_line();
    clear_enable = 1'($urandom_range(0, 1));
    wait_frames(name);
  endtask

  // model display driver: accepts 2 ce after a strobe, completes 40 ce later
  initial begin : driver
    int handled;
    handled = 0;
    forever begin
      @(negedge clk);
      if (strobe_count != handled) begin
        handled = strobe_count;
        if (!stuck) begin
          repeat (2) wait_ce();
          command_ready = 1'b0;
          repeat (40) wait_ce();
          command_ready = 1'b1;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic [2:0] cur, prev;
    logic [1:0] kind, last_kind;
    logic [EW-1:0] exp_e;
    logic prev_done;
    int width;
    prev = '0; width = 0; prev_done = 1'b0; last_kind = '0;
    forever begin
      @(negedge clk);
      cur = {wr_clr, wr_l1, wr_l2};
      if (cur != 3'b000 && prev == 3'b000) begin
        strobe_count++;
        last_strobe_ce = ce_count;
        width = 0;
        kind = wr_clr ? K_CLR : (wr_l1 ? K_L1 : K_L2);
        last_kind = kind;
        check("strobe_onehot", $countones(cur), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got kind %0d required none", kind);
        end else begin
          exp_e = exp_q.pop_front();
          check("strobe_frame", {kind, busy, dat1, dat2}, exp_e);
        end
      end
      if (cur != 3'b000) width++;
      if (cur == 3'b000 && prev != 3'b000 && !rst) check("strobe_width", width, 8);
      if (frame_done === 1'b1 && !prev_done) begin
        done_count++;
        last_done_ce = ce_count;
        check("done_state", {last_kind, busy}, {K_L2, 1'b0});
      end
      prev = cur;
      prev_done = (frame_done === 1'b1);
    end
  end

  initial begin : main
    logic [127:0] a1, a2, b1, b2;
    int s0, base, n;
    line1 = rand_line();
    line2 = rand_line();
    #5 rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_strobes", {wr_clr, wr_l1, wr_l2}, 0);
    check("rst_busy_done_err", {busy, frame_done, timeout_err}, 0);
    check("rst_dat", {dat1, dat2}, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(1'b1, "HELLO WORLD     ", rand_line(), "hello_frame");
    check("hello_line1", dat1, 128'h48454C4C4F20574F524C442020202020);

    s0 = strobe_count;
    run_frame(1'b0, rand_line(), rand_line(), "noclear_frame");
    check("noclear_strobes", strobe_count - s0, 2);

    for (int i = 0; i < 3; i++)
      run_frame(1'($urandom_range(0, 1)), rand_line(), rand_line(), "rand_frame");

    // line2 changed mid-frame, then three coalescing requests
    a1 = rand_line(); a2 = rand_line();
    clear_enable = 1'b1; line1 = a1; line2 = a2;
    push_frame(1'b1, a1, a2);
    s0 = strobe_count;
    pulse_req();
    wait_strobes(s0 + 2, "coal_l1_seen");
    repeat (10) wait_ce();
    check("in_l1_wdone", dbg_state, L1_WDONE);
    b1 = rand_line(); b2 = rand_line();
    line2 = b2;
    line1 = b1;
    push_frame(1'b1, b1, b2);
    repeat (3) begin
      pulse_req();
      repeat (3) @(negedge clk);
    end
    wait_frames("coalesce_frames");
    repeat (50) wait_ce();
    check("coalesce_strobes", strobe_count - s0, 6);

    // periodic refresh with no request
    push_frame(clear_enable, line1, line2);
    base = last_done_ce;
    s0 = strobe_count;
    wait_strobes(s0 + 1, "refresh_start");
    check_range("refresh_period", last_strobe_ce - base, 1000, 1002);
    wait_frames("refresh_frame");

    // driver never accepts: watchdog abandons, then a retry follows
    stuck = 1'b1;
    clear_enable = 1'b1; line1 = rand_line(); line2 = rand_line();
    exp_q.push_back({K_CLR, 1'b1, line1, line2});
    s0 = strobe_count;
    pulse_req();
    wait_strobes(s0 + 1, "to_first_strobe");
    base = last_strobe_ce;
    n = 0;
    while (!timeout_err && n < 3000) begin @(negedge clk); n++; end
    stuck = 1'b0;
    push_frame(1'b1, line1, line2);
    check_range("timeout_latency", ce_count - base, 100, 102);
    check("timeout_idle", {timeout_err, busy, dbg_state}, {1'b1, 1'b0, IDLE});
    wait_frames("retry_frame");
    check("timeout_sticky", timeout_err, 1);

    // reset in the middle of L1_ISSUE
    clear_enable = 1'b0; line1 = rand_line(); line2 = rand_line();
    exp_q.push_back({K_L1, 1'b1, line1, line2});
    s0 = strobe_count;
    pulse_req();
    wait_strobes(s0 + 1, "rst_l1_strobe");
    check("rst_in_l1_issue", dbg_state, L1_ISSUE);
    #2 rst = 1'b1;
    #1;
    check("rst_async_drop", {wr_l1, busy, timeout_err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    s0 = strobe_count;
    repeat (200) wait_ce();
    check("rst_no_restart", strobe_count - s0, 0);
    check("rst_idle", {busy, dbg_state}, {1'b0, IDLE});

    // final report
    check("queue_drained", exp_q.size(), 0);
    check("frame_count", done_count, exp_frames);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
